fir_out_packer: RTL and testbench

- Downstream stage of the FIR filter. Captures each signed Y_N_SIZE-bit y_n sample while the filter reports it valid.
- Buffers captured samples in a small FIFO.
- Streams each sample onto an 8-bit output bus as two bytes, low byte first then sign-extended high byte, under a valid/ready handshake.
- Fits the FIR's wider result onto the 8-bit dedicated output pins.

---
 rtl/fir_pkg.sv | 13 +
 rtl/fir_out_fifo.sv | 61 ++++++
 rtl/fir_out_packer.sv | 118 +++++++++++
 tb/tb_fir_out_packer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants and output-FSM state encoding for the FIR output stage.
package fir_pkg;

  localparam int unsigned Y_N_SIZE_DEF = 10;
  localparam int unsigned OUT_SIZE_DEF = 8;

  typedef enum logic [1:0] {
    PK_IDLE = 2'b00,
    PK_LO   = 2'b01,
    PK_HI   = 2'b10
  } pk_state_e;

endpackage

// File: rtl/fir_out_fifo.sv
// Synchronous sample FIFO; a push while full is accepted when a pop happens on the same edge.
module fir_out_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 10,
  parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_level == LW'(DEPTH));
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign dout      = r_mem[r_rptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // When full, wptr == rptr: the write lands in the slot being popped this edge.
  always_ff @(posedge clk) begin
    if (reset && w_do_push) begin
      r_mem[r_wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/fir_out_packer.sv
// Buffers signed FIR results and streams each as low byte then sign-extended high byte.
module fir_out_packer
  import fir_pkg::*;
#(
  parameter int unsigned Y_N_SIZE   = Y_N_SIZE_DEF,
  parameter int unsigned OUT_SIZE   = OUT_SIZE_DEF,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [Y_N_SIZE-1:0] y_n,
  input  logic                y_valid,
  output logic [OUT_SIZE-1:0] m_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                m_tlast,
  input  logic                clr_ovf,
  output logic                overflow,
  output logic [LVL_W-1:0]    fifo_level
);

  localparam int unsigned FLW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FLW-1:0] LvlOne = FLW'(1);

  if (!((OUT_SIZE < Y_N_SIZE) && (Y_N_SIZE <= 2 * OUT_SIZE))) begin : g_bad_width
    $error("fir_out_packer: need OUT_SIZE < Y_N_SIZE <= 2*OUT_SIZE");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fir_out_packer: FIFO_DEPTH must be a power of two >= 2");
  end

  pk_state_e           r_state;
  pk_state_e           w_state_nxt;
  logic                r_ovf;
  logic [Y_N_SIZE-1:0] w_head;
  logic [OUT_SIZE-1:0] w_hi_byte;
  logic [FLW-1:0]      w_level;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;

  assign w_pop  = (r_state == PK_HI) && m_tready;
  assign w_push = y_valid && (!w_full || w_pop);
  assign w_drop = y_valid && w_full && !w_pop;

  fir_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (Y_N_SIZE),
    .LW    (FLW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (y_n),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (w_level)
  );

  // High byte: bits above OUT_SIZE, padded with the sample's sign bit.
  for (genvar i = 0; i < OUT_SIZE; i++) begin : g_hi
    if (i < Y_N_SIZE - OUT_SIZE) begin : g_bit
      assign w_hi_byte[i] = w_head[OUT_SIZE+i];
    end else begin : g_sgn
      assign w_hi_byte[i] = w_head[Y_N_SIZE-1];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    m_tvalid    = 1'b0;
    m_tdata     = '0;
    m_tlast     = 1'b0;
    unique case (r_state)
      PK_IDLE: begin
        if (!w_empty) w_state_nxt = PK_LO;
      end
      PK_LO: begin
        m_tvalid = 1'b1;
        m_tdata  = w_head[OUT_SIZE-1:0];
        if (m_tready) w_state_nxt = PK_HI;
      end
      PK_HI: begin
        m_tvalid = 1'b1;
        m_tdata  = w_hi_byte;
        m_tlast  = 1'b1;
        // Stay busy if anything remains after this pop, including a same-edge push.
        if (m_tready) begin
          w_state_nxt = ((w_level > LvlOne) || w_push) ? PK_LO : PK_IDLE;
        end
      end
      default: w_state_nxt = PK_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= PK_IDLE;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign overflow   = r_ovf;
  assign fifo_level = LVL_W'(w_level);

endmodule

// File: tb/tb_fir_out_packer.sv
// Directed vector bench for fir_out_packer: table of single-cycle rows plus hand-written sequences.
module tb_fir_out_packer;

  logic       clk;
  logic       reset;
  logic [9:0] y_n;
  logic       y_valid;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready;
  logic       m_tlast;
  logic       clr_ovf;
  logic       overflow;
  logic [2:0] fifo_level;

  int n_checks = 0;
  int n_pass   = 0;

  fir_out_packer dut (
    .clk        (clk),
    .reset      (reset),
    .y_n        (y_n),
    .y_valid    (y_valid),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .clr_ovf    (clr_ovf),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic       yv;
    logic [9:0] y;
    logic       tr;
    logic       etv;
    logic [7:0] ed;
    logic       etl;
    logic [2:0] elvl;
    logic       eovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic yv, input logic [9:0] y, input logic tr,
                     input logic etv, input logic [7:0] ed, input logic etl,
                     input logic [2:0] elvl, input logic eovf);
    vec_t v;
    v.nm = nm; v.yv = yv; v.y = y; v.tr = tr; v.etv = etv; v.ed = ed; v.etl = etl;
    v.elvl = elvl; v.eovf = eovf;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic etv, input logic [7:0] ed,
                         input logic etl, input logic [2:0] elvl, input logic eovf);
    chk({nm, ".tvalid"}, 32'(m_tvalid), 32'(etv));
    chk({nm, ".tdata"}, 32'(m_tdata), 32'(ed));
    chk({nm, ".tlast"}, 32'(m_tlast), 32'(etl));
    chk({nm, ".level"}, 32'(fifo_level), 32'(elvl));
    chk({nm, ".ovf"}, 32'(overflow), 32'(eovf));
  endtask

  initial begin
    reset    = 1'b0;
    y_n      = '0;
    y_valid  = 1'b0;
    m_tready = 1'b0;
    clr_ovf  = 1'b0;

    // Single sample -3: FD then FF, valid two edges after capture.
    add("s1_cap",  1, 10'h3FD, 1, 0, 8'h00, 0, 1, 0);
    add("s1_lo",   0, 10'h000, 1, 1, 8'hFD, 0, 1, 0);
    add("s1_hi",   0, 10'h000, 1, 1, 8'hFF, 1, 1, 0);
    add("s1_done", 0, 10'h000, 1, 0, 8'h00, 0, 0, 0);
    // 383 then -512 back-to-back.
    add("b2b_c0",  1, 10'h17F, 1, 0, 8'h00, 0, 1, 0);
    add("b2b_lo0", 1, 10'h200, 1, 1, 8'h7F, 0, 2, 0);
    add("b2b_hi0", 0, 10'h000, 1, 1, 8'h01, 1, 2, 0);
    add("b2b_lo1", 0, 10'h000, 1, 1, 8'h00, 0, 1, 0);
    add("b2b_hi1", 0, 10'h000, 1, 1, 8'hFE, 1, 1, 0);
    add("b2b_end", 0, 10'h000, 1, 0, 8'h00, 0, 0, 0);
    // Backpressure in LO for five cycles.
    add("bp_cap",  1, 10'h0AA, 0, 0, 8'h00, 0, 1, 0);
    add("bp_lo",   0, 10'h000, 0, 1, 8'hAA, 0, 1, 0);
    for (int i = 0; i < 5; i++) add($sformatf("bp_hold%0d", i), 0, 10'h000, 0, 1, 8'hAA, 0, 1, 0);
    add("bp_hi",   0, 10'h000, 1, 1, 8'h00, 1, 1, 0);
    add("bp_end",  0, 10'h000, 1, 0, 8'h00, 0, 0, 0);

    tick();
    tick();
    chk_out("reset", 0, 8'h00, 0, 0, 0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      y_valid  = vecs[i].yv;
      y_n      = vecs[i].y;
      m_tready = vecs[i].tr;
      tick();
      chk_out(vecs[i].nm, vecs[i].etv, vecs[i].ed, vecs[i].etl, vecs[i].elvl, vecs[i].eovf);
    end

    // Overflow: six pushes under full backpressure, then drain in order and clear.
    m_tready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      y_valid = 1'b1;
      y_n     = 10'(k);
      tick();
    end
    y_valid = 1'b0;
    chk_out("ovf_full", 1, 8'h01, 0, 4, 1);
    m_tready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("ovf_lo%0d.tdata", k), 32'(m_tdata), 32'(k));
      chk($sformatf("ovf_lo%0d.tlast", k), 32'(m_tlast), 32'(0));
      tick();
      chk($sformatf("ovf_hi%0d.tdata", k), 32'(m_tdata), 32'h00);
      chk($sformatf("ovf_hi%0d.tlast", k), 32'(m_tlast), 32'(1));
      tick();
    end
    chk_out("ovf_drained", 0, 8'h00, 0, 0, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'(0));

    // Full FIFO with a pop and a push on the same edge.
    m_tready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      y_valid = 1'b1;
      y_n     = 10'h010 + 10'(k);
      tick();
    end
    y_valid = 1'b0;
    chk_out("fp_full", 1, 8'h10, 0, 4, 0);
    m_tready = 1'b1;
    tick();
    chk_out("fp_hi", 1, 8'h00, 1, 4, 0);
    y_valid = 1'b1;
    y_n     = 10'h014;
    tick();
    y_valid = 1'b0;
    chk_out("fp_swap", 1, 8'h11, 0, 4, 0);

    // Reset while in HI with three samples held.
    tick();
    tick();
    tick();
    chk_out("rst_pre", 1, 8'h00, 1, 3, 0);
    m_tready = 1'b0;
    reset    = 1'b0;
    tick();
    reset = 1'b1;
    chk_out("rst_post", 0, 8'h00, 0, 0, 0);
    m_tready = 1'b1;
    y_valid  = 1'b1;
    y_n      = 10'h001;
    tick();
    y_valid = 1'b0;
    chk_out("rst_cap", 0, 8'h00, 0, 1, 0);
    tick();
    chk_out("rst_lo", 1, 8'h01, 0, 1, 0);
    tick();
    chk_out("rst_hi", 1, 8'h00, 1, 1, 0);
    tick();
    chk_out("rst_end", 0, 8'h00, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
